// File: rtl/fsm_state_monitor.sv
// Passive monitor for a small FSM's state bus: per-state entry counts, transition count,
// illegal-encoding / never-visited / stuck detection, and a req/valid/ack per-state readout.
module fsm_state_monitor #(
   parameter int STATE_W     = 2,
   parameter int NUM_LEGAL   = 3,
   parameter int CNT_W       = 8,
   parameter int STUCK_LIMIT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 state_vld,
   input  logic [STATE_W-1:0]   state_in,
   input  logic                 rd_req,
   input  logic [STATE_W-1:0]   rd_idx,
   input  logic                 rd_ack,
   output logic                 rd_valid,
   output logic [CNT_W-1:0]     rd_data,
   output logic [CNT_W-1:0]     trans_count,
   output logic [NUM_LEGAL-1:0] unvisited_mask,
   output logic                 illegal_flag,
   output logic [STATE_W-1:0]   illegal_state,
   output logic                 stuck_flag,
   output logic                 sat_flag
);

   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_TOP   = CNT_MAX - 1'b1;
   localparam logic [CNT_W-1:0] STUCK_MAX = CNT_W'(STUCK_LIMIT);
   localparam logic [CNT_W-1:0] STUCK_TOP = STUCK_MAX - 1'b1;

   typedef enum logic {IDLE, TRACK} trk_state_t;
   typedef enum logic {RD_IDLE, RD_WAIT} rd_state_t;

   trk_state_t trk_state, trk_next;
   rd_state_t  rd_state, rd_next;

   logic [STATE_W-1:0] prev;
   logic [CNT_W-1:0]   stuck_cnt;
   logic [CNT_W-1:0]   visit [NUM_LEGAL];
   logic [CNT_W-1:0]   snap;
   logic               legal;
   logic               new_entry;
   logic               do_trans;
   logic               do_repeat;
   logic               load;
   logic               sat_evt;

   assign legal    = ({1'b0, state_in} < (STATE_W+1)'(NUM_LEGAL));
   assign rd_valid = (rd_state == RD_WAIT);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         trk_state <= IDLE;
         rd_state  <= RD_IDLE;
      end else if (clear) begin
         trk_state <= IDLE;
         rd_state  <= RD_IDLE;
      end else begin
         trk_state <= trk_next;
         rd_state  <= rd_next;
      end
   end

   // The first sample after reset/clear is an entry but never a transition.
   always_comb begin
      trk_next  = trk_state;
      new_entry = 1'b0;
      do_trans  = 1'b0;
      do_repeat = 1'b0;
      if (state_vld) begin
         case (trk_state)
            IDLE: begin
               trk_next  = TRACK;
               new_entry = 1'b1;
            end
            TRACK: begin
               if (state_in != prev) begin
                  new_entry = 1'b1;
                  do_trans  = 1'b1;
               end else begin
                  do_repeat = 1'b1;
               end
            end
            default: trk_next = IDLE;
         endcase
      end
   end

   always_comb begin
      rd_next = rd_state;
      load    = 1'b0;
      case (rd_state)
         RD_IDLE: begin
            if (rd_req) begin
               rd_next = RD_WAIT;
               load    = 1'b1;
            end
         end
         RD_WAIT: begin
            if (rd_ack) rd_next = RD_IDLE;
         end
         default: rd_next = RD_IDLE;
      endcase
   end

   always_comb begin
      snap    = '0;
      sat_evt = do_trans && (trans_count == CNT_TOP);
      for (int i = 0; i < NUM_LEGAL; i++) begin
         if (rd_idx == STATE_W'(i)) snap = visit[i];
         if (new_entry && legal && state_in == STATE_W'(i) && visit[i] == CNT_TOP)
            sat_evt = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev           <= '0;
         stuck_cnt      <= '0;
         trans_count    <= '0;
         unvisited_mask <= '1;
         illegal_flag   <= 1'b0;
         illegal_state  <= '0;
         stuck_flag     <= 1'b0;
         sat_flag       <= 1'b0;
         rd_data        <= '0;
         for (int i = 0; i < NUM_LEGAL; i++) visit[i] <= '0;
      end else if (clear) begin
         prev           <= '0;
         stuck_cnt      <= '0;
         trans_count    <= '0;
         unvisited_mask <= '1;
         illegal_flag   <= 1'b0;
         illegal_state  <= '0;
         stuck_flag     <= 1'b0;
         sat_flag       <= 1'b0;
         rd_data        <= '0;
         for (int i = 0; i < NUM_LEGAL; i++) visit[i] <= '0;
      end else begin
         if (state_vld) prev <= state_in;

         if (new_entry)
            stuck_cnt <= '0;
         else if (do_repeat && stuck_cnt != STUCK_MAX)
            stuck_cnt <= stuck_cnt + 1'b1;
         if (do_repeat && stuck_cnt == STUCK_TOP) stuck_flag <= 1'b1;

         if (do_trans && trans_count != CNT_MAX) trans_count <= trans_count + 1'b1;

         for (int i = 0; i < NUM_LEGAL; i++) begin
            if (new_entry && legal && state_in == STATE_W'(i)) begin
               unvisited_mask[i] <= 1'b0;
               if (visit[i] != CNT_MAX) visit[i] <= visit[i] + 1'b1;
            end
         end
         if (sat_evt) sat_flag <= 1'b1;

         if (state_vld && !legal) begin
            illegal_flag <= 1'b1;
            if (!illegal_flag) illegal_state <= state_in;
         end

         // Snapshot is taken once at request time so rd_data cannot move under the consumer.
         if (load) rd_data <= snap;
      end
   end

endmodule

// File: tb/tb_fsm_state_monitor.sv
// Bench for fsm_state_monitor: two instances (8-bit and 4-bit counters) on shared inputs,
// checked against an unbounded-count reference model clipped to each counter width.
module tb_fsm_state_monitor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clear = 1'b0;
   logic       state_vld = 1'b0;
   logic [1:0] state_in = '0;
   logic       rd_req = 1'b0;
   logic [1:0] rd_idx = '0;
   logic       rd_ack = 1'b0;

   logic       rv8, if8, sf8, sa8;
   logic [7:0] rd8, tc8;
   logic [2:0] um8;
   logic [1:0] is8;
   logic       rv4, if4, sf4, sa4;
   logic [3:0] rd4, tc4;
   logic [2:0] um4;
   logic [1:0] is4;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   fsm_state_monitor #(.STATE_W(2), .NUM_LEGAL(3), .CNT_W(8), .STUCK_LIMIT(16)) dut (
      .clk(clk), .rst(rst), .clear(clear), .state_vld(state_vld), .state_in(state_in),
      .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(rd_ack),
      .rd_valid(rv8), .rd_data(rd8), .trans_count(tc8), .unvisited_mask(um8),
      .illegal_flag(if8), .illegal_state(is8), .stuck_flag(sf8), .sat_flag(sa8));

   fsm_state_monitor #(.STATE_W(2), .NUM_LEGAL(3), .CNT_W(4), .STUCK_LIMIT(8)) dut4 (
      .clk(clk), .rst(rst), .clear(clear), .state_vld(state_vld), .state_in(state_in),
      .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(rd_ack),
      .rd_valid(rv4), .rd_data(rd4), .trans_count(tc4), .unvisited_mask(um4),
      .illegal_flag(if4), .illegal_state(is4), .stuck_flag(sf4), .sat_flag(sa4));

   // Reference model: true (unbounded) counts; saturation is applied only when comparing.
   int m_vis [3];
   int m_trans, m_prev, m_run, m_maxrun, m_ill_st, m_snap;
   bit m_started, m_ill, m_rv;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int clip(input int v, input int w);
      int mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) m_vis[i] = 0;
      m_trans = 0; m_prev = 0; m_run = 0; m_maxrun = 0; m_ill_st = 0; m_snap = 0;
      m_started = 0; m_ill = 0; m_rv = 0;
   endtask

   task automatic model_step();
      int s;
      if (clear) begin
         model_reset();
         return;
      end
      if (!m_rv && rd_req) begin
         m_rv   = 1;
         m_snap = (int'(rd_idx) < 3) ? m_vis[int'(rd_idx)] : 0;
      end else if (m_rv && rd_ack) begin
         m_rv = 0;
      end
      if (state_vld) begin
         s = int'(state_in);
         if (m_started && s == m_prev) begin
            m_run++;
            if (m_run > m_maxrun) m_maxrun = m_run;
         end else begin
            if (m_started) m_trans++;
            m_run = 0;
            if (s < 3) m_vis[s]++;
         end
         if (s >= 3) begin
            if (!m_ill) m_ill_st = s;
            m_ill = 1;
         end
         m_started = 1;
         m_prev    = s;
      end
   endtask

   function automatic bit any_at(input int w);
      int mx = (1 << w) - 1;
      return (m_trans >= mx) || (m_vis[0] >= mx) || (m_vis[1] >= mx) || (m_vis[2] >= mx);
   endfunction

   task automatic check_all();
      logic [2:0] mask;
      for (int i = 0; i < 3; i++) mask[i] = (m_vis[i] == 0);
      check_eq("trans8",   32'(tc8), 32'(clip(m_trans, 8)));
      check_eq("trans4",   32'(tc4), 32'(clip(m_trans, 4)));
      check_eq("mask8",    32'(um8), 32'(mask));
      check_eq("mask4",    32'(um4), 32'(mask));
      check_eq("illflag8", 32'(if8), 32'(m_ill));
      check_eq("illflag4", 32'(if4), 32'(m_ill));
      check_eq("illst8",   32'(is8), 32'(m_ill_st));
      check_eq("illst4",   32'(is4), 32'(m_ill_st));
      check_eq("stuck8",   32'(sf8), 32'(m_maxrun >= 16));
      check_eq("stuck4",   32'(sf4), 32'(m_maxrun >= 8));
      check_eq("sat8",     32'(sa8), 32'(any_at(8)));
      check_eq("sat4",     32'(sa4), 32'(any_at(4)));
      check_eq("rvalid8",  32'(rv8), 32'(m_rv));
      check_eq("rvalid4",  32'(rv4), 32'(m_rv));
      check_eq("rdata8",   32'(rd8), 32'(clip(m_snap, 8)));
      check_eq("rdata4",   32'(rd4), 32'(clip(m_snap, 4)));
   endtask

   // Called at a falling edge: drive, let one rising edge pass, then compare.
   task automatic step(input logic v, input logic [1:0] s, input logic rq,
                       input logic [1:0] ri, input logic ak, input logic cl);
      state_vld = v; state_in = s; rd_req = rq; rd_idx = ri; rd_ack = ak; clear = cl;
      @(posedge clk);
      model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic sample(input logic [1:0] s);
      step(1'b1, s, 1'b0, 2'd0, 1'b0, 1'b0);
   endtask

   initial begin
      logic [1:0] last;
      model_reset();
      repeat (2) @(negedge clk);
      check_eq("rst_mask", 32'(um8), 32'd7);
      check_eq("rst_rvalid", 32'(rv8), 32'd0);
      rst = 1'b0;
      step(0, 0, 0, 0, 0, 0);

      // entries vs transitions
      sample(0); sample(1); sample(0); sample(1);
      check_eq("seq_trans", 32'(tc8), 32'd3);
      check_eq("seq_mask", 32'(um8), 32'b100);

      // readout: hold until ack, requests ignored while valid, clear cancels
      step(0, 0, 1, 1, 0, 0);
      check_eq("rd_first", 32'(rd8), 32'd2);
      check_eq("rd_first_v", 32'(rv8), 32'd1);
      for (int i = 0; i < 3; i++) step(1, 2'(i), 1, 0, 0, 0);
      check_eq("rd_hold", 32'(rd8), 32'd2);
      step(0, 0, 0, 0, 1, 0);
      check_eq("rd_acked", 32'(rv8), 32'd0);
      step(0, 0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      check_eq("rd_clear", 32'(rv8), 32'd0);

      // illegal encoding
      sample(1); sample(3); sample(2);
      check_eq("ill_flag", 32'(if8), 32'd1);
      check_eq("ill_state", 32'(is8), 32'd3);
      check_eq("ill_trans", 32'(tc8), 32'd2);
      step(0, 0, 1, 3, 0, 0);
      check_eq("rd_illidx", 32'(rd8), 32'd0);
      step(0, 0, 0, 0, 1, 0);

      // stuck detection
      step(0, 0, 0, 0, 0, 1);
      sample(1);
      for (int i = 0; i < 15; i++) sample(1);
      check_eq("stuck_15", 32'(sf8), 32'd0);
      sample(1);
      check_eq("stuck_16", 32'(sf8), 32'd1);
      sample(0);
      check_eq("stuck_sticky", 32'(sf8), 32'd1);

      // saturation on the 4-bit instance
      step(0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 40; i++) sample(2'(i % 2));
      check_eq("sat_trans4", 32'(tc4), 32'd15);
      check_eq("sat_flag4", 32'(sa4), 32'd1);
      check_eq("sat_trans8", 32'(tc8), 32'd39);
      step(0, 0, 1, 0, 0, 0);
      check_eq("sat_visit4", 32'(rd4), 32'd15);
      check_eq("sat_visit8", 32'(rd8), 32'd20);

      // asynchronous reset in the middle of a pending readout
      #2 rst = 1'b1;
      #1;
      check_eq("arst_rvalid", 32'(rv8), 32'd0);
      check_eq("arst_trans", 32'(tc8), 32'd0);
      check_eq("arst_mask", 32'(um8), 32'd7);
      check_eq("arst_sat", 32'(sa4), 32'd0);
      check_eq("arst_stuck", 32'(sf8), 32'd0);
      check_eq("arst_rdata", 32'(rd4), 32'd0);
      model_reset();
      state_vld = 1'b0; rd_req = 1'b0; rd_ack = 1'b0; clear = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      step(0, 0, 0, 0, 0, 0);

      // randomized traffic with long dwell runs
      last = 2'd0;
      for (int n = 0; n < 3000; n++) begin
         logic [1:0] s;
         s = ($urandom_range(9) < 6) ? last : 2'($urandom_range(3));
         last = s;
         step(1'($urandom_range(9) < 7), s, 1'($urandom_range(4) == 0),
              2'($urandom_range(3)), 1'($urandom_range(2) == 0),
              1'($urandom_range(399) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
